ocm_port2_scheduler: RTL and testbench

Burst scheduler that shares the 64-bit second port of the NIOS_UART dual-port on-chip memory between two SERDES-simulation clients. One client is a read-burst client that streams stimulus samples to the channel model; the other is a write-burst client that stores result words. The scheduler grants one whole burst at a time using round-robin arbitration. It then sequences the port's address, chipselect and write controls, and buffers read data so that the reader can apply backpressure.

---
 rtl/ocm_sched_pkg.sv | 20 ++
 rtl/ocm_rd_skid_fifo.sv | 54 +++++
 rtl/ocm_port2_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ocm_port2_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocm_sched_pkg.sv
// Shared types and default sizing for the OCM port-2 burst scheduler.
package ocm_sched_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 8960;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      RD_DRAIN = 2'd2,
      WR_BURST = 2'd3
   } state_t;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } grant_t;

endpackage

// File: rtl/ocm_rd_skid_fifo.sv
// Two-entry register FIFO that holds read data while the reader stalls.
// Entry "head" is always the oldest word, so dout needs no read mux.
module ocm_rd_skid_fifo #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        count,
   output logic              valid
);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [1:0]        cnt;

   // storage and occupancy; a pop never sees an empty FIFO because pop is qualified by valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) head <= din;
               else             tail <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd2) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head;
   assign count = cnt;
   assign valid = (cnt != 2'd0);

endmodule

// File: rtl/ocm_port2_scheduler.sv
// Round-robin burst scheduler for port 2 of the shared on-chip memory.
// One whole read or write burst is granted at a time; read data lands in a
// 2-entry skid FIFO so the reader can stall without losing words.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | arbitrate; zero-length commands complete here
//   RD_BURST | issue reads while the skid FIFO can absorb the return data
//   RD_DRAIN | all reads issued; wait for the reader to take the last word
//   WR_BURST | forward each write-data beat straight to the memory port
module ocm_port2_scheduler #(
   parameter int ADDR_W = ocm_sched_pkg::ADDR_W,
   parameter int DATA_W = ocm_sched_pkg::DATA_W,
   parameter int DEPTH  = ocm_sched_pkg::DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rd_cmd_valid,
   output logic                rd_cmd_ready,
   input  logic [ADDR_W-1:0]   rd_cmd_addr,
   input  logic [ADDR_W-1:0]   rd_cmd_len,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_data_valid,
   input  logic                rd_data_ready,
   output logic                rd_done,
   input  logic                wr_cmd_valid,
   output logic                wr_cmd_ready,
   input  logic [ADDR_W-1:0]   wr_cmd_addr,
   input  logic [ADDR_W-1:0]   wr_cmd_len,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                wr_data_valid,
   output logic                wr_data_ready,
   output logic                wr_done,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);
   import ocm_sched_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE_W     = ADDR_W'(1);

   state_t            state;
   state_t            state_nxt;
   grant_t            last_grant;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] rem;
   logic              inflight;
   logic              rd_done_q;
   logic              wr_done_q;
   logic [1:0]        fifo_count;
   logic [2:0]        occ;
   logic              rd_pop;
   logic              rd_issue;
   logic              wr_beat;
   logic              rd_grant;
   logic              wr_grant;

   ocm_rd_skid_fifo #(.DATA_W(DATA_W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .pop   (rd_pop),
      .din   (mem_readdata),
      .dout  (rd_data),
      .count (fifo_count),
      .valid (rd_data_valid)
   );

   // words buffered or on their way back, after this cycle's pop
   assign rd_pop   = rd_data_valid && rd_data_ready;
   assign occ      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, rd_pop};
   assign rd_issue = (state == RD_BURST) && (occ < 3'd2);
   assign wr_beat  = (state == WR_BURST) && wr_data_valid;

   // reader wins a tie only if the writer had the previous grant
   assign rd_grant = (state == IDLE) && rd_cmd_valid && (!wr_cmd_valid || last_grant == WR);
   assign wr_grant = (state == IDLE) && wr_cmd_valid && !rd_grant;

   assign mem_byteenable = {(DATA_W/8){mem_write}};
   assign rd_done        = rd_done_q;
   assign wr_done        = wr_done_q;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and memory-port / handshake outputs
   always_comb begin
      state_nxt      = state;
      rd_cmd_ready   = 1'b0;
      wr_cmd_ready   = 1'b0;
      wr_data_ready  = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      case (state)
         IDLE: begin
            rd_cmd_ready = rd_grant;
            wr_cmd_ready = wr_grant;
            if (rd_grant && rd_cmd_len != '0)      state_nxt = RD_BURST;
            else if (wr_grant && wr_cmd_len != '0) state_nxt = WR_BURST;
         end
         RD_BURST: begin
            if (rd_issue) begin
               mem_chipselect = 1'b1;
               mem_address    = cur;
               if (rem == ONE_W) state_nxt = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (rd_pop && fifo_count == 2'd1 && !inflight) state_nxt = IDLE;
         end
         WR_BURST: begin
            wr_data_ready = 1'b1;
            if (wr_data_valid) begin
               mem_chipselect = 1'b1;
               mem_write      = 1'b1;
               mem_address    = cur;
               mem_writedata  = wr_data;
               if (rem == ONE_W) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // burst address/length counters, grant history, inflight flag and done pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur        <= '0;
         rem        <= '0;
         inflight   <= 1'b0;
         last_grant <= WR;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         inflight  <= rd_issue;
         rd_done_q <= (rd_grant && rd_cmd_len == '0) ||
                      (state == RD_DRAIN && state_nxt == IDLE);
         wr_done_q <= (wr_grant && wr_cmd_len == '0) ||
                      (state == WR_BURST && state_nxt == IDLE);
         if (rd_grant) begin
            last_grant <= RD;
            cur        <= rd_cmd_addr;
            rem        <= rd_cmd_len;
         end else if (wr_grant) begin
            last_grant <= WR;
            cur        <= wr_cmd_addr;
            rem        <= wr_cmd_len;
         end else if (rd_issue || wr_beat) begin
            cur <= (cur == LAST_ADDR) ? '0 : cur + ONE_W;
            rem <= rem - ONE_W;
         end
      end
   end

endmodule

// File: tb/tb_ocm_port2_scheduler.sv
// Bench for ocm_port2_scheduler: table of bursts plus hand sequences for
// abort-by-reset and simultaneous requests; a queue scoreboard checks every
// memory access and every read word.
module tb_ocm_port2_scheduler;
   import ocm_sched_pkg::*;

   logic                clk;
   logic                reset;
   logic                rd_cmd_valid;
   logic                rd_cmd_ready;
   logic [ADDR_W-1:0]   rd_cmd_addr;
   logic [ADDR_W-1:0]   rd_cmd_len;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_data_valid;
   logic                rd_data_ready;
   logic                rd_done;
   logic                wr_cmd_valid;
   logic                wr_cmd_ready;
   logic [ADDR_W-1:0]   wr_cmd_addr;
   logic [ADDR_W-1:0]   wr_cmd_len;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_data_valid;
   logic                wr_data_ready;
   logic                wr_done;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic [DATA_W-1:0]   mem_writedata;
   logic [DATA_W-1:0]   mem_readdata;

   ocm_port2_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .rd_cmd_valid   (rd_cmd_valid),
      .rd_cmd_ready   (rd_cmd_ready),
      .rd_cmd_addr    (rd_cmd_addr),
      .rd_cmd_len     (rd_cmd_len),
      .rd_data        (rd_data),
      .rd_data_valid  (rd_data_valid),
      .rd_data_ready  (rd_data_ready),
      .rd_done        (rd_done),
      .wr_cmd_valid   (wr_cmd_valid),
      .wr_cmd_ready   (wr_cmd_ready),
      .wr_cmd_addr    (wr_cmd_addr),
      .wr_cmd_len     (wr_cmd_len),
      .wr_data        (wr_data),
      .wr_data_valid  (wr_data_valid),
      .wr_data_ready  (wr_data_ready),
      .wr_done        (wr_done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              wr;
      logic [DATA_W-1:0] data;
   } acc_t;

   typedef struct {
      bit is_wr;
      int addr;
      int len;
      bit bp;
      int exp_acc;
      int exp_first;
      int exp_data;
      int exp_done;
   } vec_t;

   int                n_vec = 0;
   int                n_err = 0;
   int                acc_cnt = 0;
   int                rd_done_cnt = 0;
   int                wr_done_cnt = 0;
   int                out_cnt = 0;
   acc_t              acc_q[$];
   logic [DATA_W-1:0] rd_q[$];
   logic [DATA_W-1:0] shadow[int];
   logic [DATA_W-1:0] ram[int];
   vec_t              vecs[11];

   // hand-sequence scratch
   logic [DATA_W-1:0] arb_wq[$];
   bit                gexp[4];
   int                g, ra, wa, kk, done0, aa;
   bit                gr, gw, beat;
   logic [DATA_W-1:0] dd;

   function automatic logic [DATA_W-1:0] preload(int a);
      return {32'(a), 32'hA5A5_0000 ^ 32'(a)};
   endfunction

   function automatic logic [DATA_W-1:0] exp_word(int a);
      return shadow.exists(a) ? shadow[a] : preload(a);
   endfunction

   // memory port model: one-cycle registered read
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) ram[int'(mem_address)] = mem_writedata;
         else mem_readdata <= ram.exists(int'(mem_address)) ? ram[int'(mem_address)]
                                                            : preload(int'(mem_address));
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic miss(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got activity expected none at %0t", name, $time);
   endtask

   task automatic monitor();
      acc_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            out_cnt = 0;
         end else begin
            chk("cmd_ready_onehot", 64'(rd_cmd_ready & wr_cmd_ready), 64'h0);
            if (mem_chipselect) begin
               acc_cnt++;
               if (acc_q.size() == 0) miss("acc_unexpected");
               else begin
                  e = acc_q.pop_front();
                  chk("mem_address", 64'(mem_address), 64'(e.addr));
                  chk("mem_write", 64'(mem_write), 64'(e.wr));
                  if (e.wr) chk("mem_writedata", mem_writedata, e.data);
               end
               chk("mem_byteenable", 64'(mem_byteenable), mem_write ? 64'hFF : 64'h0);
               if (!mem_write) out_cnt++;
            end
            if (rd_data_valid && rd_data_ready) begin
               if (rd_q.size() == 0) miss("rd_unexpected");
               else chk("rd_data", rd_data, rd_q.pop_front());
               out_cnt--;
            end
            chk("outstanding_le2", 64'(out_cnt > 2), 64'h0);
            if (rd_done) rd_done_cnt++;
            if (wr_done) wr_done_cnt++;
         end
      end
   endtask

   task automatic check_outs_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({rd_cmd_ready, wr_cmd_ready, rd_data_valid, rd_done, wr_data_ready,
                               wr_done, mem_chipselect, mem_write, mem_address, mem_byteenable}), 64'h0);
      chk({tag, "_rd_data"}, rd_data, 64'h0);
      chk({tag, "_writedata"}, mem_writedata, 64'h0);
   endtask

   task automatic run_burst(input vec_t v, input int vi);
      int a, k, first_lat, data_lat, done_lat, acc0, dn0, ndone;
      bit bt;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] wq[$];
      a = v.addr;
      for (int i = 0; i < v.len; i++) begin
         if (v.is_wr) begin
            d = {$urandom, $urandom};
            wq.push_back(d);
            shadow[a] = d;
            acc_q.push_back('{addr: ADDR_W'(a), wr: 1'b1, data: d});
         end else begin
            acc_q.push_back('{addr: ADDR_W'(a), wr: 1'b0, data: '0});
            rd_q.push_back(exp_word(a));
         end
         a = (a == DEPTH - 1) ? 0 : a + 1;
      end
      first_lat = -1; data_lat = -1; done_lat = -1; k = -1;
      acc0 = acc_cnt;
      dn0  = v.is_wr ? wr_done_cnt : rd_done_cnt;
      @(posedge clk); #1;
      if (v.is_wr) begin
         wr_cmd_valid = 1'b1; wr_cmd_addr = ADDR_W'(v.addr); wr_cmd_len = ADDR_W'(v.len);
      end else begin
         rd_cmd_valid = 1'b1; rd_cmd_addr = ADDR_W'(v.addr); rd_cmd_len = ADDR_W'(v.len);
      end
      for (int c = 0; c < 400 && done_lat < 0; c++) begin
         rd_data_ready = v.bp ? (c % 3 == 0) : 1'b1;
         wr_data_valid = (wq.size() != 0);
         wr_data       = (wq.size() != 0) ? wq[0] : '0;
         @(negedge clk);
         if (k < 0) begin
            if (v.is_wr ? wr_cmd_ready : rd_cmd_ready) k = 0;
         end else begin
            k++;
            if (first_lat < 0 && mem_chipselect) first_lat = k;
            if (data_lat < 0 && rd_data_valid) data_lat = k;
            if (v.is_wr ? wr_done : rd_done) done_lat = k;
         end
         bt = wr_data_valid && wr_data_ready;
         @(posedge clk); #1;
         if (k == 0) begin
            rd_cmd_valid = 1'b0;
            wr_cmd_valid = 1'b0;
         end
         if (bt) void'(wq.pop_front());
      end
      rd_cmd_valid  = 1'b0;
      wr_cmd_valid  = 1'b0;
      wr_data_valid = 1'b0;
      rd_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      ndone = (v.is_wr ? wr_done_cnt : rd_done_cnt) - dn0;
      chk($sformatf("v%0d_done_seen", vi), 64'(done_lat >= 0), 64'h1);
      chk($sformatf("v%0d_acc_count", vi), 64'(acc_cnt - acc0), 64'(v.exp_acc));
      chk($sformatf("v%0d_first_access", vi), 64'(first_lat), 64'(v.exp_first));
      chk($sformatf("v%0d_first_rd_valid", vi), 64'(data_lat), 64'(v.exp_data));
      if (v.exp_done >= 0) chk($sformatf("v%0d_done_latency", vi), 64'(done_lat), 64'(v.exp_done));
      chk($sformatf("v%0d_done_pulses", vi), 64'(ndone), 64'h1);
      chk($sformatf("v%0d_queues_empty", vi), 64'(acc_q.size() + rd_q.size()), 64'h0);
   endtask

   initial begin
      reset = 1'b1;
      rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_len = '0; rd_data_ready = 1'b1;
      wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_len = '0;
      wr_data = '0; wr_data_valid = 1'b0;
      fork
         monitor();
      join_none

      //          wr  addr  len bp  acc first data done
      vecs[0]  = '{0, 100,  4,  0,  4,  1,    3,   7};
      vecs[1]  = '{1, 8958, 4,  0,  4,  1,   -1,   5};
      vecs[2]  = '{0, 8958, 4,  0,  4,  1,    3,   7};
      vecs[3]  = '{0, 300,  0,  0,  0, -1,   -1,   1};
      vecs[4]  = '{1, 40,   0,  0,  0, -1,   -1,   1};
      vecs[5]  = '{0, 8958, 8,  1,  8,  1,    3,  -1};
      vecs[6]  = '{1, 1000, 1,  0,  1,  1,   -1,   2};
      vecs[7]  = '{0, 1000, 1,  0,  1,  1,    3,   4};
      vecs[8]  = '{0, 8959, 2,  0,  2,  1,    3,   5};
      vecs[9]  = '{1, 5,    6,  0,  6,  1,   -1,   7};
      vecs[10] = '{0, 5,    6,  1,  6,  1,    3,  -1};

      #2;
      check_outs_zero("reset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      foreach (vecs[i]) run_burst(vecs[i], i);

      // abort a read burst with reset while data is in the skid FIFO
      aa = 500;
      for (int i = 0; i < 8; i++) begin
         acc_q.push_back('{addr: ADDR_W'(aa), wr: 1'b0, data: '0});
         rd_q.push_back(exp_word(aa));
         aa++;
      end
      rd_data_ready = 1'b1;
      @(posedge clk); #1;
      rd_cmd_valid = 1'b1; rd_cmd_addr = ADDR_W'(500); rd_cmd_len = ADDR_W'(8);
      kk = -1;
      for (int c = 0; c < 20 && kk < 0; c++) begin
         @(negedge clk);
         if (rd_cmd_ready) kk = 0;
         @(posedge clk); #1;
      end
      rd_cmd_valid = 1'b0;
      chk("abort_cmd_accepted", 64'(kk), 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("abort_pre_valid", 64'(rd_data_valid), 64'h1);
      done0 = rd_done_cnt;
      reset = 1'b1;
      #1;
      check_outs_zero("abort");
      acc_q.delete();
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_no_done", 64'(rd_done_cnt - done0), 64'h0);

      // both clients request continuously: grants must alternate starting with the reader
      gexp = '{1'b0, 1'b1, 1'b0, 1'b1};
      g = 0; ra = 3000; wa = 2000;
      @(posedge clk); #1;
      rd_cmd_addr = ADDR_W'(ra); rd_cmd_len = ADDR_W'(2);
      wr_cmd_addr = ADDR_W'(wa); wr_cmd_len = ADDR_W'(2);
      rd_cmd_valid = 1'b1; wr_cmd_valid = 1'b1; rd_data_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         wr_data_valid = (arb_wq.size() != 0);
         wr_data       = (arb_wq.size() != 0) ? arb_wq[0] : '0;
         @(negedge clk);
         gr = 1'b0; gw = 1'b0;
         if (g < 4 && (rd_cmd_ready || wr_cmd_ready)) begin
            chk($sformatf("arb_grant%0d_is_wr", g), 64'(wr_cmd_ready), 64'(gexp[g]));
            if (rd_cmd_ready) begin
               for (int i = 0; i < 2; i++) begin
                  acc_q.push_back('{addr: ADDR_W'(ra + i), wr: 1'b0, data: '0});
                  rd_q.push_back(exp_word(ra + i));
               end
               gr = 1'b1;
            end else begin
               for (int i = 0; i < 2; i++) begin
                  dd = {$urandom, $urandom};
                  arb_wq.push_back(dd);
                  shadow[wa + i] = dd;
                  acc_q.push_back('{addr: ADDR_W'(wa + i), wr: 1'b1, data: dd});
               end
               gw = 1'b1;
            end
            g++;
         end
         beat = wr_data_valid && wr_data_ready;
         @(posedge clk); #1;
         if (beat) void'(arb_wq.pop_front());
         if (gr) begin ra += 8; rd_cmd_addr = ADDR_W'(ra); end
         if (gw) begin wa += 8; wr_cmd_addr = ADDR_W'(wa); end
         if (g == 4) begin rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; end
      end
      wr_data_valid = 1'b0;
      chk("arb_grant_count", 64'(g), 64'h4);
      chk("arb_queues_empty", 64'(acc_q.size() + rd_q.size()), 64'h0);

      // read back the arbitration writes
      run_burst('{1'b0, 2000, 2, 1'b0, 2, 1, 3, 5}, 11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
